// File: rtl/memctl_arb_if.sv
// Request/response bundle between the requesters and the memctl_arb RAM arbiter.
// Port i occupies bit i of each per-port vector and slice [i*W +: W] of each packed field.
interface memctl_arb_if #(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 8
);
    logic [NPORTS-1:0]        req_valid;
    logic [NPORTS-1:0]        req_ready;
    logic [NPORTS-1:0]        req_we;
    logic [NPORTS*ADDR_W-1:0] req_addr;
    logic [NPORTS*DATA_W-1:0] req_wdata;
    logic [NPORTS-1:0]        rsp_valid;
    logic [NPORTS*DATA_W-1:0] rsp_rdata;
    logic [NPORTS-1:0]        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/memctl_arb.sv
// Round-robin arbiter of NPORTS requesters onto one synchronous RAM bank, fixed RD_LAT response latency.
// Optional out-of-range checking (drop/zero/err) is enabled by defining MEMCTL_BOUNDS_CHECK_EN.
module memctl_arb #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned MEM_WORDS = 65536,
    parameter int unsigned NPORTS    = 2,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    memctl_arb_if.slave  bus
);
    localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int unsigned IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned PD = (RD_LAT > 1) ? RD_LAT - 1 : 1;

    logic [DATA_W-1:0] mbank [MEM_WORDS];

    logic [PW-1:0]     last;
    logic [PW-1:0]     grant_idx;
    logic              grant_found;
    logic              acc;
    logic [NPORTS-1:0] ready_c;
    int unsigned       cand;

    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;
    logic [IW-1:0]     idx;
    logic              oob;
    logic [DATA_W-1:0] ent_data;

    logic              fin_vld;
    logic [PW-1:0]     fin_port;
    logic              fin_err;
    logic [DATA_W-1:0] fin_data;

    // First valid port searching upward from last+1, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned k = 1; k <= NPORTS; k++) begin
            cand = (32'(last) + k) % NPORTS;
            if (!grant_found && bus.req_valid[PW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

    assign acc = grant_found & rst_n;

    always_comb begin
        ready_c            = '0;
        ready_c[grant_idx] = acc;
    end

    assign bus.req_ready = ready_c;

    assign sel_addr  = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign sel_we    = bus.req_we[grant_idx];
    assign sel_wdata = bus.req_wdata[grant_idx*DATA_W +: DATA_W];
    assign idx       = sel_addr[IW-1:0];

`ifdef MEMCTL_BOUNDS_CHECK_EN
    assign oob = ({1'b0, sel_addr} >= (ADDR_W+1)'(MEM_WORDS));
`else
    // Upper address bits are ignored so the address wraps onto the bank.
    logic unused_addr_hi;
    assign unused_addr_hi = ^sel_addr;
    assign oob            = 1'b0;
`endif

    // Write acknowledgements and out-of-range reads carry zero data.
    assign ent_data = (sel_we || oob) ? '0 : mbank[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= PW'(NPORTS - 1);
        end else if (acc) begin
            last <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (acc && sel_we && !oob) begin
            mbank[idx] <= sel_wdata;
        end
    end

    // The final response stage is the output register; extra latency comes from this pipe.
    if (RD_LAT == 1) begin : g_direct
        assign fin_vld  = acc;
        assign fin_port = grant_idx;
        assign fin_err  = oob;
        assign fin_data = ent_data;
    end else begin : g_pipe
        logic [PD-1:0]     p_vld;
        logic [PD-1:0]     p_err;
        logic [PW-1:0]     p_port [PD];
        logic [DATA_W-1:0] p_data [PD];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p_vld <= '0;
                p_err <= '0;
                for (int i = 0; i < int'(PD); i++) begin
                    p_port[i] <= '0;
                    p_data[i] <= '0;
                end
            end else begin
                p_vld[0]  <= acc;
                p_err[0]  <= oob;
                p_port[0] <= grant_idx;
                p_data[0] <= ent_data;
                for (int i = 1; i < int'(PD); i++) begin
                    p_vld[i]  <= p_vld[i-1];
                    p_err[i]  <= p_err[i-1];
                    p_port[i] <= p_port[i-1];
                    p_data[i] <= p_data[i-1];
                end
            end
        end

        assign fin_vld  = p_vld[PD-1];
        assign fin_port = p_port[PD-1];
        assign fin_err  = p_err[PD-1];
        assign fin_data = p_data[PD-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= '0;
        end else begin
            bus.rsp_valid <= '0;
            if (fin_vld) begin
                bus.rsp_valid[fin_port]                   <= 1'b1;
                bus.rsp_rdata[fin_port*DATA_W +: DATA_W] <= fin_data;
                bus.rsp_err[fin_port]                     <= fin_err;
            end
        end
    end
endmodule

// File: doc/memctl_arb.md
# memctl_arb

Parametrised, multi-port successor to the single-port byte RAM controller. It arbitrates NPORTS independent requesters onto one synchronous RAM bank with valid/ready request handshakes and round-robin fairness. Data width, depth and read latency are configurable, and every access returns a response with a fixed, configurable latency. It sits between the CPU/DMA masters and on-chip RAM in the chipset.

## Interface
Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 17, request address width (word address).
- MEM_WORDS, 65536, RAM depth in words; must be ≤ 2**ADDR_W.
- NPORTS, 2, requester count; must be ≥ 1.
- RD_LAT, 1, response latency in cycles after acceptance; must be ≥ 1.

Ports:
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NPORTS  per-port request valid.
- req_ready  out  NPORTS  per-port grant; combinational.
- req_we  in  NPORTS  per-port write (1) / read (0).
- req_addr  in  NPORTS*ADDR_W  per-port word address; port i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NPORTS*DATA_W  per-port write data.
- rsp_valid  out  NPORTS  one-cycle response strobe per port.
- rsp_rdata  out  NPORTS*DATA_W  read data; 0 for write responses.
- rsp_err  out  NPORTS  out-of-range flag, valid with rsp_valid.

## Operation
- At most one request is accepted per cycle. A transfer occurs on req_valid[i] & req_ready[i].
- Round-robin arbiter with last-grant pointer `last`. The search starts at port last+1 (mod NPORTS), and the first port with req_valid set is granted.
- req_ready is one-hot or zero, and is never asserted for a port whose req_valid is low.
- `last` updates to the granted port only on a transfer and holds otherwise.
- Requesters must hold addr/we/wdata stable while valid and not ready; requests are not dropped.
- Write: mbank[addr] <= wdata at the accepting edge.
- Read: mbank[addr] is sampled at the accepting edge.
- Each transfer enters an RD_LAT-deep response pipeline carrying {port, err, data}.
- Responses have no backpressure. The requester must consume rsp_valid when it pulses.
- Write responses are acknowledgements: rsp_valid=1, rsp_rdata=0.
- Same-address ordering is preserved:
  - A read accepted the cycle after a write returns the new data.
  - Since only one access is accepted per cycle, a simultaneous read and write to one address is impossible.
- RAM contents are not reset.

## Timing
- Reset values: req_ready=0 (combinational, held 0 while rst_n low), rsp_valid=0, rsp_rdata=0, rsp_err=0, pipeline valids cleared, last=NPORTS-1 (so port 0 wins first).
- Reset mid-operation: in-flight responses are discarded and none is emitted after reset release. Writes already accepted remain in RAM.
- Latency: a transfer at edge N produces rsp_valid on that port for exactly the cycle after edge N+RD_LAT-1 completes. RD_LAT=1 means the response is visible in the cycle following acceptance.
- Throughput: one transfer per cycle sustained. With all ports valid, grants rotate 0,1,…,NPORTS-1,0,…
- Single requester continuously valid: granted every cycle.
- NPORTS=1: req_ready = req_valid.

## Configuration
- MEMCTL_BOUNDS_CHECK_EN defined:
  - An address ≥ MEM_WORDS is accepted normally.
  - A write to such an address is dropped (RAM unchanged).
  - A read from such an address returns rsp_rdata=0.
  - rsp_err=1 with the response.
- MEMCTL_BOUNDS_CHECK_EN undefined:
  - The address is truncated to $clog2(MEM_WORDS) bits, so it wraps.
  - rsp_err is tied to 0.

## Test plan
- Reset: assert rst_n=0 mid-stream with two reads in flight. Required: rsp_valid=0 throughout reset and afterwards, no stale responses, req_ready=0.
- Single port 0: write 0xA5 to addr 0x0010, then read 0x0010 on the next cycle. Required: write ack at +RD_LAT, then rsp_rdata[7:0]=0xA5 with rsp_err=0.
- NPORTS=2, both ports valid for 4 cycles. Required: grants 0,1,0,1 and responses arrive in the same order on the matching ports.
- Port 1 alone valid, then port 0 joins. Required: port 0 is granted next, proving the pointer advanced past 1.
- RD_LAT=3, back-to-back reads of 0x0000..0x0003 preloaded with 1,2,3,4. Required: rsp_rdata 1,2,3,4 on consecutive cycles starting 3 cycles after the first acceptance.
- Read at addr 0x10000 (MEM_WORDS=65536):
  - With MEMCTL_BOUNDS_CHECK_EN: rsp_err=1, rdata=0, and addr 0 is unchanged by a write to 0x10000.
  - Without it: the write aliases to addr 0.
